// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache memory-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int unsigned LINE_W_DEFAULT = 256;

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between I-cache and D-cache,
// with saturating grant/contention counters.
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEFAULT,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  cnt_i_grant,
  output logic [CNT_W-1:0]  cnt_d_grant,
  output logic [CNT_W-1:0]  cnt_conflict
);

  arb_state_t state;
  arb_owner_t last_owner;

  logic i_req, d_req, in_idle, grant_i, grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign in_idle = (state == IDLE);
  // On contention the requester that did not own the port last time wins.
  assign grant_i = in_idle && i_req && (!d_req || (last_owner == OWN_D));
  assign grant_d = in_idle && d_req && (!i_req || (last_owner == OWN_I));

  // Request strobes are latched at grant so they stay asserted until pmem_resp
  // even if the owner misbehaves and drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_I;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= SERVE_I;
            last_owner <= OWN_I;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
          end else if (grant_d) begin
            state      <= SERVE_D;
            last_owner <= OWN_D;
            pmem_read  <= d_read & ~d_write;
            pmem_write <= d_write;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      SERVE_I: pmem_address = i_address;
      SERVE_D: begin
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_i (
    .clk(clk), .rst(rst), .inc(grant_i), .cnt(cnt_i_grant)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
    .clk(clk), .rst(rst), .inc(grant_d), .cnt(cnt_d_grant)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk(clk), .rst(rst), .inc(in_idle && i_req && d_req), .cnt(cnt_conflict)
  );

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write));
  a_i_sticky: assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_I) |-> i_read);
  a_d_sticky: assert property (@(posedge clk) disable iff (rst)
    (state == SERVE_D) |-> (d_read || d_write));
  a_no_idle_resp: assert property (@(posedge clk) disable iff (rst)
    !(in_idle && pmem_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter: grant order, data steering, counters, async reset.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;

  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [31:0]   cnt_i_grant, cnt_d_grant, cnt_conflict;

  logic [LW-1:0] i_rdata4, d_rdata4, pmem_wdata4;
  logic          i_resp4, d_resp4, pmem_read4, pmem_write4;
  logic [AW-1:0] pmem_address4;
  logic [3:0]    cnt_i4, cnt_d4, cnt_c4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict)
  );

  cache_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata4), .i_resp(i_resp4),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata4), .d_resp(d_resp4),
    .pmem_read(pmem_read4), .pmem_write(pmem_write4), .pmem_address(pmem_address4),
    .pmem_wdata(pmem_wdata4), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .cnt_i_grant(cnt_i4), .cnt_d_grant(cnt_d4), .cnt_conflict(cnt_c4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    vectors++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin miscompares++;
      $display("FAIL reset_pmem_req: got rd=%b wr=%b want 0/0", pmem_read, pmem_write); end
    vectors++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin miscompares++;
      $display("FAIL reset_resp: got i=%b d=%b want 0/0", i_resp, d_resp); end
    vectors++; if (cnt_i_grant !== 32'd0 || cnt_d_grant !== 32'd0 || cnt_conflict !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cnt_i_grant, cnt_d_grant, cnt_conflict); end
    vectors++; if (pmem_address !== 32'd0 || pmem_wdata !== 256'd0) begin miscompares++;
      $display("FAIL reset_addr_wdata: got addr=%h want 0", pmem_address); end
    rst = 1'b0;
  endtask

  task automatic test_i_only();
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    do_reset();
    i_read = 1'b1; i_address = 32'h4000_0000;
    #1;
    vectors++; if (pmem_read !== 1'b0) begin miscompares++;
      $display("FAIL i_only_latency: got pmem_read=%b want 0", pmem_read); end
    tick();
    vectors++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin miscompares++;
      $display("FAIL i_only_req: got rd=%b wr=%b want 1/0", pmem_read, pmem_write); end
    vectors++; if (pmem_address !== 32'h4000_0000) begin miscompares++;
      $display("FAIL i_only_addr: got %h want 40000000", pmem_address); end
    repeat (3) tick();
    vectors++; if (i_resp !== 1'b0 || pmem_read !== 1'b1) begin miscompares++;
      $display("FAIL i_only_wait: got resp=%b rd=%b want 0/1", i_resp, pmem_read); end
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    vectors++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin miscompares++;
      $display("FAIL i_only_resp: got i=%b d=%b want 1/0", i_resp, d_resp); end
    vectors++; if (i_rdata !== line) begin miscompares++;
      $display("FAIL i_only_rdata: got %h want %h", i_rdata, line); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    vectors++; if (i_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'd0) begin miscompares++;
      $display("FAIL i_only_done: got resp=%b rd=%b addr=%h want 0/0/0", i_resp, pmem_read, pmem_address); end
    vectors++; if (cnt_i_grant !== 32'd1 || cnt_d_grant !== 32'd0) begin miscompares++;
      $display("FAIL i_only_cnt: got i=%0d d=%0d want 1/0", cnt_i_grant, cnt_d_grant); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0200;
    d_read = 1'b1; d_address = 32'h0000_0100;
    tick();
    vectors++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0100) begin miscompares++;
      $display("FAIL sim_first_d: got rd=%b addr=%h want 1/00000100", pmem_read, pmem_address); end
    vectors++; if (cnt_d_grant !== 32'd1 || cnt_i_grant !== 32'd0 || cnt_conflict !== 32'd1) begin
      miscompares++;
      $display("FAIL sim_cnt1: got i=%0d d=%0d c=%0d want 0/1/1", cnt_i_grant, cnt_d_grant, cnt_conflict); end
    pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}};
    #1;
    vectors++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== {8{32'hDEAD_BEEF}}) begin
      miscompares++;
      $display("FAIL sim_d_resp: got d=%b i=%b want 1/0", d_resp, i_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    tick();
    vectors++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0200) begin miscompares++;
      $display("FAIL sim_then_i: got rd=%b addr=%h want 1/00000200", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    #1;
    vectors++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin miscompares++;
      $display("FAIL sim_i_resp: got i=%b d=%b want 1/0", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    vectors++; if (cnt_i_grant !== 32'd1 || cnt_d_grant !== 32'd1 || cnt_conflict !== 32'd1) begin
      miscompares++;
      $display("FAIL sim_cnt2: got i=%0d d=%0d c=%0d want 1/1/1", cnt_i_grant, cnt_d_grant, cnt_conflict); end
  endtask

  task automatic test_d_writeback();
    logic [LW-1:0] line;
    line = {8{32'h1234_5678}};
    do_reset();
    d_write = 1'b1; d_address = 32'h0000_1240; d_wdata = line;
    tick();
    vectors++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin miscompares++;
      $display("FAIL wb_req: got wr=%b rd=%b want 1/0", pmem_write, pmem_read); end
    vectors++; if (pmem_wdata !== line || pmem_address !== 32'h0000_1240) begin miscompares++;
      $display("FAIL wb_data: got addr=%h wdata=%h want 00001240/%h", pmem_address, pmem_wdata, line); end
    tick();
    vectors++; if (d_resp !== 1'b0) begin miscompares++;
      $display("FAIL wb_early_resp: got %b want 0", d_resp); end
    pmem_resp = 1'b1;
    #1;
    vectors++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin miscompares++;
      $display("FAIL wb_resp: got d=%b i=%b want 1/0", d_resp, i_resp); end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    #1;
    vectors++; if (pmem_write !== 1'b0 || pmem_wdata !== 256'd0 || cnt_d_grant !== 32'd1) begin
      miscompares++;
      $display("FAIL wb_done: got wr=%b cnt_d=%0d want 0/1", pmem_write, cnt_d_grant); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0A00;
    d_read = 1'b1; d_address = 32'h0000_0D00;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      tick();
      vectors++; if (pmem_read !== 1'b1 || pmem_address !== (exp_d ? 32'h0000_0D00 : 32'h0000_0A00)) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got rd=%b addr=%h want owner d=%b", t, pmem_read, pmem_address, exp_d); end
      pmem_resp = 1'b1;
      #1;
      vectors++; if (d_resp !== exp_d || i_resp !== !exp_d) begin miscompares++;
        $display("FAIL b2b_resp%0d: got d=%b i=%b want d=%b", t, d_resp, i_resp, exp_d); end
      tick();
      pmem_resp = 1'b0;
      if (t == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
    end
    #1;
    vectors++; if (cnt_i_grant !== 32'd2 || cnt_d_grant !== 32'd2 || cnt_conflict !== 32'd4) begin
      miscompares++;
      $display("FAIL b2b_cnt: got i=%0d d=%0d c=%0d want 2/2/4", cnt_i_grant, cnt_d_grant, cnt_conflict); end
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    d_write = 1'b1; d_address = 32'h0000_3300; d_wdata = {8{32'hCAFE_F00D}};
    tick();
    tick();
    vectors++; if (pmem_write !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_pre: got wr=%b want 1", pmem_write); end
    #2;
    rst = 1'b1;
    pmem_resp = 1'b1;
    #1;
    vectors++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || d_resp !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_async: got wr=%b rd=%b d_resp=%b want 0/0/0", pmem_write, pmem_read, d_resp); end
    vectors++; if (pmem_address !== 32'd0 || cnt_d_grant !== 32'd0) begin miscompares++;
      $display("FAIL rstmid_idle: got addr=%h cnt_d=%0d want 0/0", pmem_address, cnt_d_grant); end
    pmem_resp = 1'b0; d_write = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (pmem_write !== 1'b0 || cnt_d_grant !== 32'd0 || cnt_conflict !== 32'd0 || cnt_i_grant !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_after: got wr=%b cnts=%0d/%0d/%0d want 0/0/0/0", pmem_write,
               cnt_i_grant, cnt_d_grant, cnt_conflict); end
  endtask

  task automatic test_saturation();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0040;
    for (int t = 0; t < 20; t++) begin
      tick();
      pmem_resp = 1'b1;
      #1;
      vectors++; if (i_resp4 !== 1'b1) begin miscompares++;
        $display("FAIL sat_resp%0d: got %b want 1", t, i_resp4); end
      if (t == 13) begin
        vectors++; if (cnt_i4 !== 4'hE) begin miscompares++;
          $display("FAIL sat_cnt14: got %h want e", cnt_i4); end
      end
      tick();
      pmem_resp = 1'b0;
    end
    i_read = 1'b0;
    #1;
    vectors++; if (cnt_i4 !== 4'hF) begin miscompares++;
      $display("FAIL sat_cnt20: got %h want f", cnt_i4); end
    vectors++; if (cnt_i_grant !== 32'd20) begin miscompares++;
      $display("FAIL sat_wide_cnt: got %0d want 20", cnt_i_grant); end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_d_writeback();
    test_back_to_back();
    test_reset_mid_serve();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
